// File: rtl/lsu_mem_unit.sv
// lsu_mem_unit: load/store unit between the execute stage and a single-port data bus.
// Builds byte strobes and lane-shifted write data for stores. Extracts and sign- or
// zero-extends load data. Runs a request/response handshake with the bus.
// Optional macro LSU_MISALIGN_SPLIT_EN: an access that crosses a bus word is done as
// two beats. Without the macro, such an access ends with rsp_err and no bus request.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   req_*                        core request: valid/ready, we, funct3, addr, wdata
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion with load data or error
//   mem_req_valid/mem_req_ready  bus request handshake; mem_addr/we/wstrb/wdata payload
//   mem_rsp_valid/mem_rdata      bus read data or write acknowledge
module lsu_mem_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int unsigned B     = XLEN / 8;
  localparam int unsigned B2    = 2 * B;
  localparam int unsigned XLEN2 = 2 * XLEN;
  localparam int unsigned OFF_W = $clog2(B);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t state_q, state_d;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [XLEN-1:0]   beat0_q;
  logic [7:0]        sh_hi;
`endif

  logic              accept;
  logic              cur_we;
  logic [2:0]        cur_funct3;
  logic [ADDR_W-1:0] cur_addr;
  logic [XLEN-1:0]   cur_wdata;
  logic [OFF_W-1:0]  off;
  logic [1:0]        lg;
  logic [3:0]        sz;
  logic [7:0]        sh_lo;
  logic              crossing;
  logic              legal;
  logic [ADDR_W-1:0] aligned;
  logic [B2-1:0]     strb_mask;
  logic [XLEN-1:0]   ld_lo, ld_hi, ld_sh, ld_mask, ld_ext;
  logic              ld_msb;

  logic              rsp_err_d;
  logic [XLEN-1:0]   rsp_rdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_we_d;
  logic [B-1:0]      mem_wstrb_d;
  logic [XLEN-1:0]   mem_wdata_d;

  assign accept = req_valid && req_ready;

  // Request view: live inputs while idle, captured copy for the rest of the access
  always_comb begin
    cur_we     = (state_q == IDLE) ? req_we     : we_q;
    cur_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
    cur_addr   = (state_q == IDLE) ? req_addr   : addr_q;
    cur_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;
  end

  // Access geometry: byte offset, size, crossing, bus-aligned address
  always_comb begin
    off       = cur_addr[OFF_W-1:0];
    lg        = cur_funct3[1:0];
    sz        = 4'(1) << lg;
    sh_lo     = 8'({off, 3'b000});
`ifdef LSU_MISALIGN_SPLIT_EN
    sh_hi     = 8'(XLEN) - sh_lo;
`endif
    crossing  = (5'(off) + 5'(sz)) > 5'(B);
    aligned   = cur_addr & ~ADDR_W'(B - 1);
    strb_mask = B2'((9'(1) << sz) - 9'(1));
  end

  // funct3 legality; doubleword and LWU exist only on the 64-bit datapath
  always_comb begin
    if (cur_we) begin
      legal = (cur_funct3 inside {3'b000, 3'b001, 3'b010}) ||
              ((XLEN == 64) && (cur_funct3 == 3'b011));
    end else begin
      legal = (cur_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
              ((XLEN == 64) && (cur_funct3 inside {3'b011, 3'b110}));
    end
  end

  // Load extraction: {beat1, beat0} shifted down by the offset, then extended
  always_comb begin
    ld_lo = mem_rdata;
    ld_hi = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
    if (state_q == WAIT1) begin
      ld_lo = beat0_q;
      ld_hi = mem_rdata;
    end
`endif
    ld_sh   = XLEN'({ld_hi, ld_lo} >> sh_lo);
    ld_mask = '1;
    ld_msb  = ld_sh[XLEN-1];
    case (lg)
      2'd0:    begin ld_mask = XLEN'(8'hFF);        ld_msb = ld_sh[7];  end
      2'd1:    begin ld_mask = XLEN'(16'hFFFF);     ld_msb = ld_sh[15]; end
      2'd2:    begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_msb = ld_sh[31]; end
      default: ;
    endcase
    ld_ext = ld_sh & ld_mask;
    if (!cur_funct3[2] && ld_msb) ld_ext = ld_ext | ~ld_mask;
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wstrb_d = '0;
    mem_wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ0;
          if (!legal) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end
`ifndef LSU_MISALIGN_SPLIT_EN
          if (crossing) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end
`endif
        end
      end
      REQ0: if (mem_req_ready) state_d = WAIT0;
      WAIT0: begin
        if (mem_rsp_valid) begin
          state_d = RESP;
          if (!cur_we) rsp_rdata_d = ld_ext;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (crossing) begin
            state_d     = REQ1;
            rsp_rdata_d = '0;
          end
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      REQ1: if (mem_req_ready) state_d = WAIT1;
      WAIT1: begin
        if (mem_rsp_valid) begin
          state_d = RESP;
          if (!cur_we) rsp_rdata_d = ld_ext;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == REQ0) begin
      mem_addr_d  = aligned;
      mem_we_d    = cur_we;
      mem_wstrb_d = B'(strb_mask << off);
      mem_wdata_d = cur_wdata << sh_lo;
    end
`ifdef LSU_MISALIGN_SPLIT_EN
    if (state_d == REQ1) begin
      mem_addr_d  = aligned + ADDR_W'(B);
      mem_we_d    = cur_we;
      mem_wstrb_d = B'((strb_mask << off) >> B);
      mem_wdata_d = cur_wdata >> sh_hi;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wstrb     <= '0;
      mem_wdata     <= '0;
    end else begin
      state_q       <= state_d;
      req_ready     <= (state_d == IDLE);
      rsp_valid     <= (state_d == RESP);
      rsp_err       <= rsp_err_d;
      rsp_rdata     <= rsp_rdata_d;
      mem_req_valid <= (state_d == REQ0) || (state_d == REQ1);
      mem_addr      <= mem_addr_d;
      mem_we        <= mem_we_d;
      mem_wstrb     <= mem_wstrb_d;
      mem_wdata     <= mem_wdata_d;
    end
  end

  // Request capture and first-beat latch
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
`ifdef LSU_MISALIGN_SPLIT_EN
    if ((state_q == WAIT0) && mem_rsp_valid) beat0_q <= mem_rdata;
`endif
  end

endmodule

// File: doc/lsu_mem_unit.md
Name: lsu_mem_unit

Overview:
- Load/store unit between the RV32I/RV64I execute stage and a single-port data bus.
- Parametrised successor of the fixed byte/half/word memory-access scheme: generalised to XLEN = 32 or 64, adding doubleword and LWU access.
- Generates byte strobes and shifts write data into lane position; extracts, sign-extends or zero-extends load data.
- Runs a bus handshake state machine, optionally splitting accesses that cross a bus word into two beats.

Parameters:
- XLEN, 32, datapath and bus data width; legal values are 32 and 64.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V load/store funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal funct3, or unsupported misaligned access.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts the request this cycle.
- mem_addr  out  ADDR_W  bus-word-aligned address.
- mem_we  out  1  write enable.
- mem_wstrb  out  XLEN/8  byte strobes.
- mem_wdata  out  XLEN  lane-positioned write data.
- mem_rsp_valid  in  1  read data / write acknowledge. Exactly one per accepted request, in order, at least 1 cycle after acceptance.
- mem_rdata  in  XLEN  read data, valid with mem_rsp_valid.

Behaviour:
- Definitions: B = XLEN/8; off = addr mod B; sz = 1/2/4/8 bytes.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; with XLEN=64 also 011 LD and 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW; with XLEN=64 also 011 SD.
  - Any other value is illegal.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Reset: state = IDLE. Registered outputs cleared: mem_req_valid=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wstrb=0, mem_we=0, mem_addr=0, mem_wdata=0. req_ready=1 from the first cycle after rst.
- IDLE: on req_valid&&req_ready, capture all request fields.
  - Illegal funct3, or crossing access without the macro: go to RESP with rsp_err=1 and no bus activity.
  - Otherwise go to REQ0.
- Crossing access: off+sz > B. Misalignment contained within one bus word is a single beat.
- REQ0:
  - mem_req_valid=1, mem_addr = addr & ~(B-1), mem_we = req_we.
  - mem_wstrb = ((1<<sz)-1) << off, truncated to B bits.
  - mem_wdata = wdata << 8*off.
  - Hold all of these stable until mem_req_ready, then go to WAIT0.
- WAIT0: on mem_rsp_valid, latch mem_rdata; go to REQ1 if crossing, else RESP.
- REQ1:
  - mem_addr = (aligned addr + B) mod 2^ADDR_W.
  - mem_wstrb = remaining low bytes.
  - mem_wdata = wdata >> 8*(B-off).
  - Hold until mem_req_ready, then go to WAIT1.
- WAIT1: on mem_rsp_valid, latch the upper word; go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. No backpressure.
  - Loads: concatenate {beat1, beat0} >> 8*off, take the low sz bytes, then sign- or zero-extend.
- Minimum latency with zero-wait bus (accept at T, mem_req_ready at T+1, mem_rsp_valid at T+2): rsp_valid at T+3. Split access: T+5. Error: T+1.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored. This includes stray responses after a mid-operation reset.
- rst in any state: IDLE on the next edge, mem_req_valid dropped, no rsp_valid for the aborted access.

Optional Feature:
- LSU_MISALIGN_SPLIT_EN defined: crossing accesses are performed as two beats via REQ1/WAIT1.
- Undefined: REQ1/WAIT1 logic is removed; crossing accesses complete at T+1 with rsp_err=1 and no bus request.

Test Plan:
1. XLEN=32, LB at 0x1003, mem_rdata=0x80AA5511 -> mem_addr=0x1000, rsp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
2. SH at 0x1002, wdata=0x0000BEEF -> mem_addr=0x1000, mem_wstrb=4'b1100, mem_wdata=0xBEEF0000, mem_we=1. rsp_valid at T+3 with zero-wait bus; mem_req_ready held low 3 cycles delays it exactly 3 cycles with request fields stable.
3. With macro: LW at 0x1002, beats 0x1000->0x44332211 and 0x1004->0x88776655 -> rsp_rdata=0x66554433 at T+5. Without macro: rsp_err=1 at T+1, mem_req_valid never asserted.
4. With macro: SW at 0x1003, wdata=0xAABBCCDD -> beat0 0x1000 / strb 1000 / wdata 0xDD000000; beat1 0x1004 / strb 0111 / wdata 0x00AABBCC. Separately, LW at 0xFFFFFFFE -> second beat mem_addr=0x00000000.
5. XLEN=32, funct3=011 load -> rsp_err=1, rsp_rdata=0. XLEN=64, LWU at 0x4, mem_rdata=0xF0000000_00000000 -> rsp_rdata=0x00000000F0000000.
6. rst asserted during WAIT0, then mem_rsp_valid pulsed -> IDLE, req_ready=1, rsp_valid stays 0. A following LW completes normally.
